// File: rtl/pds_pkg.sv
// Shared types and defaults for the PDS port sequencer and its helpers.
// Port count and settle time defaults match the PDS power-budget controller.
package pds_pkg;

    localparam int PDS_NUM_PORTS  = 4;
    localparam int PDS_SETTLE_CYC = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RAMP = 1'b1
    } seq_state_e;

    typedef logic [$clog2(PDS_NUM_PORTS)-1:0] port_idx_t;

    // Index width that stays legal for a single-port build.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pds_prio_enc.sv
// Combinational lowest-index-first priority encoder.
// Shared with the controller bench scoreboards, so keep it dependency-free.
module pds_prio_enc #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [W-1:0] idx
);

    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = W'(i);
            end
        end
    end

endmodule

// File: rtl/pds_port_sequencer.sv
// Drives PSE port power switches from controller grants, ramping one port at a time
// with a fixed settle window; powers down at once on grant loss, global kill or fault.
module pds_port_sequencer
    import pds_pkg::*;
#(
    parameter int NUM_PORTS  = PDS_NUM_PORTS,
    parameter int SETTLE_CYC = PDS_SETTLE_CYC,
    localparam int CNT_W     = $clog2(SETTLE_CYC + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] on_req,
    input  logic                 ports_off,
    input  logic [NUM_PORTS-1:0] fault,
    output logic [NUM_PORTS-1:0] pwr_en,
    output logic [NUM_PORTS-1:0] pwr_good,
    output logic [NUM_PORTS-1:0] fault_latched,
    output logic                 busy
);

    localparam int IDX_W = idx_width(NUM_PORTS);
    localparam logic [0:0] S_IDLE = IDLE;
    localparam logic [0:0] S_RAMP = RAMP;

    logic [0:0]           state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     cur;

    logic [NUM_PORTS-1:0] pending;
    logic                 pick_vld;
    logic [IDX_W-1:0]     pick_idx;
    logic                 cur_abort;

    logic [NUM_PORTS-1:0] en_nxt;
    logic [NUM_PORTS-1:0] good_nxt;
    logic [NUM_PORTS-1:0] flt_nxt;

    assign pending   = ports_off ? '0 : (on_req & ~pwr_en & ~fault_latched);
    assign cur_abort = ~on_req[cur] | fault[cur] | ports_off;
    assign busy      = (state == S_RAMP);

    pds_prio_enc #(
        .N (NUM_PORTS),
        .W (IDX_W)
    ) u_prio_enc (
        .req   (pending),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    // A grant drop outranks a coincident fault, so a trip requires the grant still present.
    always_comb begin
        en_nxt   = pwr_en;
        good_nxt = pwr_good;
        flt_nxt  = fault_latched;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!on_req[i] || (fault[i] && pwr_en[i]) || ports_off) begin
                en_nxt[i]   = 1'b0;
                good_nxt[i] = 1'b0;
            end else begin
                if (state == S_IDLE && pick_vld && pick_idx == IDX_W'(i)) begin
                    en_nxt[i] = 1'b1;
                end
                if (state == S_RAMP && cnt == '0 && cur == IDX_W'(i)) begin
                    good_nxt[i] = 1'b1;
                end
            end
            if (!on_req[i]) begin
                flt_nxt[i] = 1'b0;
            end else if (fault[i] && pwr_en[i]) begin
                flt_nxt[i] = 1'b1;
            end
        end
    end

    // The counter is only loaded on ramp start and stops at zero, so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            cur   <= '0;
        end else if (state == S_IDLE) begin
            if (pick_vld) begin
                state <= S_RAMP;
                cnt   <= CNT_W'(SETTLE_CYC - 1);
                cur   <= pick_idx;
            end
        end else begin
            if (cur_abort || cnt == '0) begin
                state <= S_IDLE;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwr_en        <= '0;
            pwr_good      <= '0;
            fault_latched <= '0;
        end else begin
            pwr_en        <= en_nxt;
            pwr_good      <= good_nxt;
            fault_latched <= flt_nxt;
        end
    end

    a_good_implies_en : assert property (@(posedge clk) disable iff (!rst_n)
        (pwr_good & ~pwr_en) == '0);

    a_single_ramp : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(pwr_en & ~pwr_good));

endmodule
